johnson_decoder: RTL and testbench

//   Receive-side companion to the johnson_counter: samples a BITS-wide Johnson (twisted-ring) code.
//   - Decodes it to a binary index 0..2*BITS-1.
//   - Checks code legality and step-by-step sequence order.
//   - Tracks lock state and keeps a saturating error count.

---
 rtl/johnson_pkg.sv | 36 +++
 rtl/johnson_decoder_if.sv | 38 +++
 rtl/johnson_code_check.sv | 18 +
 rtl/johnson_decoder.sv | 100 ++++++++++
 tb/tb_johnson_decoder.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers and decoder FSM encoding.
// Functions take the code zero-extended to 32 bits plus the real code width.
package johnson_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } jd_state_e;

    // Legal Johnson codes are exactly those with at most one adjacent-bit transition.
    function automatic logic jc_is_legal(input logic [31:0] code, input int unsigned bits);
        int unsigned trans;
        trans = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((i + 1 < bits) && (code[i] != code[i+1])) trans++;
        end
        return (trans < 2);
    endfunction

    function automatic int unsigned jc_to_idx(input logic [31:0] code, input int unsigned bits);
        int unsigned p;
        logic        msb;
        p   = 0;
        msb = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits && code[i]) p++;
            if (i == bits - 1) msb = code[i];
        end
        return (msb | ~code[0]) ? p : (2 * bits - p);
    endfunction

    function automatic int unsigned jc_next_idx(input int unsigned idx, input int unsigned bits);
        return (idx + 1 >= 2 * bits) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample/status bundle between a Johnson-code source and johnson_decoder.
// onehot_out exists only when JOHNSON_DEC_ONEHOT_EN is defined.
interface johnson_decoder_if #(
    parameter int unsigned BITS  = 4,
    parameter int unsigned ERR_W = 8
);
    localparam int unsigned IDX_W = $clog2(2 * BITS);

    logic             in_valid;
    logic [BITS-1:0]  j_in;
    logic             err_clr;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             legal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
`ifdef JOHNSON_DEC_ONEHOT_EN
    logic [2*BITS-1:0] onehot_out;
`endif

    modport master (
        output in_valid, j_in, err_clr,
        input  idx_out, idx_valid, legal, seq_err, locked, err_cnt
`ifdef JOHNSON_DEC_ONEHOT_EN
        , input onehot_out
`endif
    );

    modport slave (
        input  in_valid, j_in, err_clr,
        output idx_out, idx_valid, legal, seq_err, locked, err_cnt
`ifdef JOHNSON_DEC_ONEHOT_EN
        , output onehot_out
`endif
    );

endinterface

// File: rtl/johnson_code_check.sv
// Combinational Johnson-code legality check and binary index decode.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int unsigned BITS  = 4,
    parameter int unsigned IDX_W = $clog2(2 * BITS)
) (
    input  logic [BITS-1:0]  j_in,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        legal = jc_is_legal(32'(j_in), BITS);
        idx   = IDX_W'(jc_to_idx(32'(j_in), BITS));
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decode, legality/sequence check, lock FSM, saturating error count.
// Optional one-hot index output enabled by JOHNSON_DEC_ONEHOT_EN.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned BITS  = 4,
    parameter int unsigned ERR_W = 8
) (
    input logic          clk,
    input logic          reset_n,
    johnson_decoder_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(2 * BITS);
    localparam int unsigned SEQ_LEN = 2 * BITS;

    logic             chk_legal;
    logic [IDX_W-1:0] chk_idx;

    johnson_code_check #(
        .BITS  (BITS),
        .IDX_W (IDX_W)
    ) u_code_check (
        .j_in  (bus.j_in),
        .legal (chk_legal),
        .idx   (chk_idx)
    );

    jd_state_e        state_q;
    logic [IDX_W-1:0] prev_q;
    logic [IDX_W-1:0] idx_q;
    logic             idx_valid_q;
    logic             legal_q;
    logic             seq_err_q;
    logic [ERR_W-1:0] err_cnt_q;
`ifdef JOHNSON_DEC_ONEHOT_EN
    logic [SEQ_LEN-1:0] onehot_q;
`endif

    logic step_err;
    logic sample_err;

    // A repeat of the same code also counts as out of step.
    always_comb begin
        step_err   = chk_legal && (state_q == ST_LOCKED) &&
                     (chk_idx != IDX_W'(jc_next_idx(32'(prev_q), BITS)));
        sample_err = bus.in_valid && (!chk_legal || step_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            prev_q      <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            legal_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
`ifdef JOHNSON_DEC_ONEHOT_EN
            onehot_q    <= '0;
`endif
        end else begin
            idx_valid_q <= bus.in_valid;
            seq_err_q   <= sample_err;
            if (bus.in_valid) begin
                legal_q <= chk_legal;
                if (chk_legal) begin
                    idx_q   <= chk_idx;
                    prev_q  <= chk_idx;
                    state_q <= ST_LOCKED;
`ifdef JOHNSON_DEC_ONEHOT_EN
                    onehot_q <= SEQ_LEN'(1) << chk_idx;
`endif
                end else begin
                    state_q <= ST_HUNT;
`ifdef JOHNSON_DEC_ONEHOT_EN
                    onehot_q <= '0;
`endif
                end
            end
            // Clear wins over a same-cycle error.
            if (bus.err_clr) begin
                err_cnt_q <= '0;
            end else if (sample_err && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

    assign bus.idx_out   = idx_q;
    assign bus.idx_valid = idx_valid_q;
    assign bus.legal     = legal_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.err_cnt   = err_cnt_q;
`ifdef JOHNSON_DEC_ONEHOT_EN
    assign bus.onehot_out = onehot_q;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (BITS=4, ERR_W=8) against a table-driven model.
module tb_johnson_decoder;

    localparam int unsigned BITS  = 4;
    localparam int unsigned ERR_W = 8;
    localparam int          N     = 2 * BITS;

    logic clk;
    logic reset_n;

    johnson_decoder_if #(.BITS(BITS), .ERR_W(ERR_W)) bus ();

    johnson_decoder #(
        .BITS  (BITS),
        .ERR_W (ERR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [BITS-1:0] seq [N];

    // Reference model state
    bit m_locked;
    int m_prev;
    int m_idx;
    bit m_legal;
    int m_cnt;
    int m_onehot;
    bit e_vld;
    bit e_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int lookup(input logic [BITS-1:0] code);
        for (int i = 0; i < N; i++) if (seq[i] == code) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_prev = 0; m_idx = 0; m_legal = 0; m_cnt = 0; m_onehot = 0;
        e_vld = 0; e_err = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".idx_out"},   32'(bus.idx_out),   32'(m_idx));
        check_eq({tag, ".idx_valid"}, 32'(bus.idx_valid), 32'(e_vld));
        check_eq({tag, ".legal"},     32'(bus.legal),     32'(m_legal));
        check_eq({tag, ".seq_err"},   32'(bus.seq_err),   32'(e_err));
        check_eq({tag, ".locked"},    32'(bus.locked),    32'(m_locked));
        check_eq({tag, ".err_cnt"},   32'(bus.err_cnt),   32'(m_cnt));
`ifdef JOHNSON_DEC_ONEHOT_EN
        check_eq({tag, ".onehot_out"}, 32'(bus.onehot_out), 32'(m_onehot));
`endif
    endtask

    task automatic step(input string tag, input bit v, input logic [BITS-1:0] code,
                        input bit clr);
        int k;
        @(negedge clk);
        bus.in_valid = v;
        bus.j_in     = code;
        bus.err_clr  = clr;
        @(posedge clk);
        #1;
        k     = lookup(code);
        e_vld = v;
        e_err = 0;
        if (v) begin
            if (k >= 0) begin
                if (m_locked && k != (m_prev + 1) % N) e_err = 1;
                m_locked = 1; m_prev = k; m_idx = k; m_legal = 1; m_onehot = 1 << k;
            end else begin
                e_err = 1; m_locked = 0; m_legal = 0; m_onehot = 0;
            end
        end
        if (clr) m_cnt = 0;
        else if (e_err && m_cnt < (1 << ERR_W) - 1) m_cnt++;
        check_outputs(tag);
    endtask

    task automatic async_reset_check();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
    endtask

    initial begin
        int pos;
        logic [BITS-1:0] q;
        q = '0;
        for (int i = 0; i < N; i++) begin
            seq[i] = q;
            q = {~q[0], q[BITS-1:1]};
        end

        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.j_in     = '0;
        bus.err_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) step("clean", 1'b1, seq[i % N], 1'b0);

        step("illegal", 1'b1, 4'b1010, 1'b0);
        step("relock", 1'b1, 4'b0000, 1'b0);
        step("skip_a", 1'b1, 4'b1000, 1'b0);
        step("skip_b", 1'b1, 4'b1110, 1'b0);
        step("skip_c", 1'b1, 4'b1111, 1'b0);

        pos = 4;
        for (int i = 0; i < 6; i++) begin
            step("gap_idle", 1'b0, 4'($urandom), 1'b0);
            pos = (pos + 1) % N;
            step("gap_step", 1'b1, seq[pos], 1'b0);
        end

        repeat (300) step("sat", 1'b1, 4'b0101, 1'b0);
        step("clr_err", 1'b1, 4'b1010, 1'b1);

        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, seq[i], 1'b0);
        async_reset_check();
        step("post_rst", 1'b1, seq[3], 1'b0);

        pos = 3;
        for (int i = 0; i < 400; i++) begin
            logic [BITS-1:0] c;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10) c = 4'($urandom);
            else if (r < 20) begin
                pos = int'($urandom_range(0, N - 1));
                c   = seq[pos];
            end else begin
                pos = (pos + 1) % N;
                c   = seq[pos];
            end
            step("rand", ($urandom_range(0, 3) != 0), c, ($urandom_range(0, 31) == 0));
            if (i == 200) async_reset_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
